// File: rtl/line_buffer_fetch.sv
// Ping-pong scanline prefetcher: SDRAM framebuffer words into two line banks.
// Optional underrun detection is built when LB_UNDERRUN_DET_EN is defined.
module line_buffer_fetch #(
    parameter logic [21:0] FB_BASE    = 22'h000000,
    parameter int          WORDS_LINE = 80,
    parameter int          VIS_LINES  = 480,
    parameter int          LAST_LINE  = 524,
    parameter int          TRIG_X     = 799
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         new_frame,
    input  logic [9:0]   DrawX,
    input  logic [9:0]   DrawY,
    input  logic         lb_sdram_wait,
    input  logic         lb_sdram_ac,
    input  logic [127:0] lb_sdram_data,
    output logic         lb_sdram_rd,
    output logic [21:0]  lb_sdram_addr,
    output logic         lb_Busy,
    output logic         lb_done,
    output logic [15:0]  pixel_out,
    output logic         underrun
);
    localparam int IW = $clog2(WORDS_LINE);

    typedef enum logic [1:0] {IDLE, FETCH, PAUSE} state_t;

    state_t        state;
    state_t        state_nx;
    logic [9:0]    line_q;
    logic [IW-1:0] idx;
    logic [21:0]   addr_q;
    logic          done_q;
    logic [9:0]    nl;
    logic          trig;
    logic          busy;
    logic          wr;
    logic          last;
    logic [127:0]  rd_word;

    logic [127:0]  mem [0:1][0:WORDS_LINE-1];

    assign nl   = (DrawY == 10'(LAST_LINE)) ? 10'd0 : DrawY + 10'd1;
    assign trig = (DrawX == 10'(TRIG_X)) && (nl < 10'(VIS_LINES));
    assign busy = (state != IDLE);
    assign wr   = (state == FETCH) && lb_sdram_ac;
    assign last = (idx == IW'(WORDS_LINE - 1));

    assign lb_Busy       = busy;
    assign lb_done       = done_q;
    assign lb_sdram_addr = addr_q;

    always_comb begin
        state_nx    = state;
        lb_sdram_rd = 1'b0;
        unique case (state)
            IDLE: begin
                if (trig)
                    state_nx = lb_sdram_wait ? PAUSE : FETCH;
            end
            FETCH: begin
                // An ack completes the beat even if wait rises alongside it
                lb_sdram_rd = lb_sdram_ac || !lb_sdram_wait;
                if (lb_sdram_ac) begin
                    if (last)
                        state_nx = IDLE;
                end else if (lb_sdram_wait) begin
                    state_nx = PAUSE;
                end
            end
            PAUSE: begin
                if (!lb_sdram_wait)
                    state_nx = FETCH;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            line_q    <= 10'd0;
            idx       <= '0;
            addr_q    <= 22'd0;
            done_q    <= 1'b0;
            pixel_out <= 16'd0;
        end else begin
            state <= state_nx;
            if (state == IDLE && trig) begin
                line_q <= nl;
                idx    <= '0;
                addr_q <= FB_BASE + 22'(nl) * 22'(WORDS_LINE);
            end else if (wr) begin
                idx    <= idx + IW'(1);
                addr_q <= addr_q + 22'd1;
            end
            if (wr && last && line_q == 10'(VIS_LINES - 1))
                done_q <= 1'b1;
            else if (new_frame)
                done_q <= 1'b0;
            if (DrawX < 10'(WORDS_LINE * 8) && DrawY < 10'(VIS_LINES))
                pixel_out <= rd_word[{DrawX[2:0], 4'b0000} +: 16];
            else
                pixel_out <= 16'd0;
        end
    end

    // Bank RAM has no reset; a reset cycle only blocks the write
    always_ff @(posedge clk) begin
        if (wr && !reset)
            mem[line_q[0]][idx] <= lb_sdram_data;
    end

    assign rd_word = mem[DrawY[0]][DrawX[9:3]];

`ifdef LB_UNDERRUN_DET_EN
    logic under_q;

    always_ff @(posedge clk) begin
        if (reset)
            under_q <= 1'b0;
        else if (busy && ((DrawX == 10'd0 && DrawY == line_q) || trig))
            under_q <= 1'b1;
    end

    assign underrun = under_q;
`else
    assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_line_buffer_fetch.sv
// Self-checking bench for line_buffer_fetch: randomized arbiter handshake
// against a word-count reference model of the fetch and the line banks.
module tb_line_buffer_fetch;
    localparam logic [21:0] FB_BASE = 22'h000000;
`ifdef LB_UNDERRUN_DET_EN
    localparam bit UD = 1'b1;
`else
    localparam bit UD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         new_frame;
    logic [9:0]   DrawX;
    logic [9:0]   DrawY;
    logic         lb_sdram_wait;
    logic         lb_sdram_ac;
    logic [127:0] lb_sdram_data;
    logic         lb_sdram_rd;
    logic [21:0]  lb_sdram_addr;
    logic         lb_Busy;
    logic         lb_done;
    logic [15:0]  pixel_out;
    logic         underrun;

    int checks = 0;
    int errors = 0;

    logic [127:0] ref_mem [2][80];
    bit           ref_ok  [2][80];
    bit           exp_done;
    bit           exp_under;

    line_buffer_fetch #(.FB_BASE(FB_BASE)) dut (
        .clk(clk), .reset(reset), .new_frame(new_frame),
        .DrawX(DrawX), .DrawY(DrawY),
        .lb_sdram_wait(lb_sdram_wait), .lb_sdram_ac(lb_sdram_ac),
        .lb_sdram_data(lb_sdram_data), .lb_sdram_rd(lb_sdram_rd),
        .lb_sdram_addr(lb_sdram_addr), .lb_Busy(lb_Busy),
        .lb_done(lb_done), .pixel_out(pixel_out), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_checks();
        chk("rst_rd", lb_sdram_rd, 0);
        chk("rst_addr", lb_sdram_addr, 0);
        chk("rst_busy", lb_Busy, 0);
        chk("rst_done", lb_done, 0);
        chk("rst_pixel", pixel_out, 0);
        chk("rst_underrun", underrun, 0);
    endtask

    // Arbiter + reference: expected word address is base + line*80 + words taken
    task automatic run_fetch(input int dy, input int wpct, input int apct,
                             input int slo, input int shi, input int peek,
                             input int abort_at);
        logic [9:0]   nl;
        logic [21:0]  ea;
        logic [127:0] d;
        int cnt;
        int cyc;
        bit pw, pa, er, fnow, upend;
        nl = (dy == 524) ? 10'd0 : 10'(dy + 1);
        @(negedge clk);
        DrawY = 10'(dy);
        DrawX = 10'd799;
        lb_sdram_ac = 1'b0;
        lb_sdram_wait = (slo == 0) || ($urandom_range(99) < wpct);
        pw = lb_sdram_wait;
        pa = 1'b0;
        cnt = 0;
        cyc = 0;
        @(negedge clk);
        while (cnt < 80 && cnt != abort_at && cyc < 3000) begin
            lb_sdram_ac = 1'b0;
            upend = 1'b0;
            lb_sdram_wait = (cyc >= slo && cyc <= shi) || ($urandom_range(99) < wpct);
            if (cyc == peek) begin
                DrawX = 10'd0;
                DrawY = nl;
                upend = UD;
            end else begin
                DrawX = 10'd100;
                DrawY = 10'(dy);
            end
            #1;
            fnow = !pw || pa;
            er = fnow && !lb_sdram_wait;
            ea = FB_BASE + 22'(nl) * 22'd80 + 22'(cnt);
            chk("busy", lb_Busy, 1);
            chk("rd", lb_sdram_rd, er);
            chk("addr", lb_sdram_addr, ea);
            chk("done", lb_done, exp_done);
            chk("underrun", underrun, exp_under);
            pa = 1'b0;
            if (er && $urandom_range(99) < apct) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                if (nl == 10'd1 && cnt == 2)
                    d = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
                lb_sdram_ac = 1'b1;
                lb_sdram_data = d;
                ref_mem[nl[0]][cnt] = d;
                ref_ok[nl[0]][cnt] = 1'b1;
                pa = 1'b1;
            end else if (!fnow && $urandom_range(3) == 0) begin
                lb_sdram_ac = 1'b1;
                lb_sdram_data = {$urandom, $urandom, $urandom, $urandom};
            end
            pw = lb_sdram_wait;
            @(negedge clk);
            if (upend)
                exp_under = 1'b1;
            if (pa) begin
                cnt++;
                if (cnt == 80 && nl == 10'd479)
                    exp_done = 1'b1;
            end
            cyc++;
        end
        lb_sdram_ac = 1'b0;
        lb_sdram_wait = 1'b0;
        DrawX = 10'd100;
        DrawY = 10'(dy);
        if (cyc >= 3000) begin
            chk("fetch_timeout", 32'(cnt), 80);
        end else if (cnt == abort_at) begin
            reset = 1'b1;
            @(posedge clk);
            #1;
            exp_done = 1'b0;
            exp_under = 1'b0;
            reset_checks();
            @(negedge clk);
            reset = 1'b0;
        end else begin
            #1;
            chk("end_busy", lb_Busy, 0);
            chk("end_rd", lb_sdram_rd, 0);
            chk("end_done", lb_done, exp_done);
        end
    endtask

    task automatic pix(input int x, input int y);
        logic [127:0] w;
        logic [15:0]  e;
        bit known;
        @(negedge clk);
        DrawX = 10'(x);
        DrawY = 10'(y);
        known = 1'b1;
        e = 16'd0;
        if (x < 640 && y < 480) begin
            known = ref_ok[y % 2][x / 8];
            w = ref_mem[y % 2][x / 8];
            e = w[16 * (x % 8) +: 16];
        end
        @(posedge clk);
        #1;
        if (known)
            chk("pixel", pixel_out, e);
    endtask

    initial begin
        reset = 1'b1;
        new_frame = 1'b0;
        DrawX = 10'd0;
        DrawY = 10'd0;
        lb_sdram_wait = 1'b0;
        lb_sdram_ac = 1'b0;
        lb_sdram_data = '0;
        exp_done = 1'b0;
        exp_under = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int w = 0; w < 80; w++)
                ref_ok[b][w] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_checks();
        @(negedge clk);
        reset = 1'b0;

        run_fetch(10, 0, 100, -1, -1, -1, -1);
        run_fetch(11, 0, 100, 20, 29, -1, -1);

        run_fetch(0, 0, 100, -1, -1, -1, -1);
        pix(21, 1);
        chk("pix_w2_p5", pixel_out, 16'h0005);
        pix(700, 1);
        chk("pix_x700", pixel_out, 16'h0000);

        for (int i = 0; i < 6; i++)
            run_fetch(int'($urandom_range(477)), 30, 60, -1, -1, -1, -1);
        for (int i = 0; i < 40; i++)
            pix(int'($urandom_range(719)), int'($urandom_range(499)));

        run_fetch(478, 20, 70, -1, -1, -1, -1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("done_hold", lb_done, exp_done);
        end
        @(negedge clk);
        new_frame = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
        exp_done = 1'b0;
        #1;
        chk("done_clear", lb_done, exp_done);
        for (int y = 479; y <= 523; y += 11) begin
            @(negedge clk);
            DrawY = 10'(y);
            DrawX = 10'd799;
            @(negedge clk);
            DrawX = 10'd100;
            #1;
            chk("no_trig_busy", lb_Busy, 0);
            chk("no_trig_rd", lb_sdram_rd, 0);
        end

        run_fetch(20, 0, 80, 0, 5, 2, -1);
        @(negedge clk);
        #1;
        chk("underrun_sticky", underrun, exp_under);

        run_fetch(524, 0, 100, -1, -1, -1, 40);
        run_fetch(5, 25, 75, -1, -1, -1, -1);
        for (int i = 0; i < 10; i++)
            pix(int'($urandom_range(639)), int'($urandom_range(1)) * 2 + 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
